fifo_write_arbiter: RTL and testbench

FIFO_WRITE_ARBITER -- requirements
Module: fifo_write_arbiter

---
 rtl/fifo_write_arbiter.sv | 125 ++++++++++++
 tb/tb_fifo_write_arbiter.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter that lets one of NUM_REQ requesters write a burst of up to MAX_BURST beats into a FIFO.
// Optional FIFO_WR_ARB_STALL_CNT_EN adds a saturating stall_count output.
module fifo_write_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            gnt,
  output logic [DATA_WIDTH-1:0]         fifo_data_in,
  output logic                          fifo_write_en,
  input  logic                          fifo_full,
  output logic [$clog2(NUM_REQ)-1:0]    owner,
`ifdef FIFO_WR_ARB_STALL_CNT_EN
  output logic [15:0]                   stall_count,
`endif
  output logic                          busy
);

  localparam int OW = $clog2(NUM_REQ);
  localparam int CW = $clog2(MAX_BURST) + 1;

  typedef enum logic {
    ST_IDLE,
    ST_BURST
  } state_e;

  state_e          state_q, state_d;
  logic [OW-1:0]   owner_q, owner_d;
  logic [CW-1:0]   beat_cnt_q, beat_cnt_d;
  logic [OW-1:0]   next_owner;
  logic            owner_req;
  logic [DATA_WIDTH-1:0] owner_data;
  logic            beat;

  always_comb begin
    owner_req  = 1'b0;
    owner_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (owner_q == OW'(i)) begin
        owner_req  = req[i];
        owner_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Search starts one past the previous owner so every requester gets its turn.
  always_comb begin
    next_owner = owner_q;
    for (int k = NUM_REQ; k >= 1; k--) begin
      if (req[(int'(owner_q) + k) % NUM_REQ]) begin
        next_owner = OW'((int'(owner_q) + k) % NUM_REQ);
      end
    end
  end

  assign busy = (state_q == ST_BURST);
  assign beat = busy && owner_req && !fifo_full;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    state_d    = state_q;
    owner_d    = owner_q;
    beat_cnt_d = beat_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (|req) begin
          owner_d    = next_owner;
          beat_cnt_d = '0;
          state_d    = ST_BURST;
        end
      end
      ST_BURST: begin
        if (!owner_req) begin
          state_d = ST_IDLE;
        end else if (beat) begin
          beat_cnt_d = beat_cnt_q + CW'(1);
          if (beat_cnt_q + CW'(1) == CW'(MAX_BURST)) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments and reset asynchronously.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      owner_q    <= OW'(NUM_REQ - 1);
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) gnt[i] = beat && (owner_q == OW'(i));
  end

  assign fifo_write_en = beat;
  assign fifo_data_in  = busy ? owner_data : '0;
  assign owner         = owner_q;

`ifdef FIFO_WR_ARB_STALL_CNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (busy && owner_req && fifo_full && stall_cnt_q != 16'hFFFF) stall_cnt_d = stall_cnt_q + 16'd1;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) stall_cnt_q <= '0;
    else          stall_cnt_q <= stall_cnt_d;
  end

  assign stall_count = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed table-driven bench for fifo_write_arbiter (default instance plus a MAX_BURST=1 instance).
module tb_fifo_write_arbiter;

  logic        clock;
  logic        reset_n;
  logic [3:0]  req, req1;
  logic [31:0] req_data, req_data1;
  logic        fifo_full, fifo_full1;
  logic [3:0]  gnt, gnt1;
  logic [7:0]  fifo_data_in, fifo_data_in1;
  logic        fifo_write_en, fifo_write_en1;
  logic [1:0]  owner, owner1;
  logic        busy, busy1;
`ifdef FIFO_WR_ARB_STALL_CNT_EN
  logic [15:0] stall_count, stall_count1;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  fifo_write_arbiter #(.NUM_REQ(4), .DATA_WIDTH(8), .MAX_BURST(4)) dut (
    .clock(clock), .reset_n(reset_n), .req(req), .req_data(req_data), .gnt(gnt),
    .fifo_data_in(fifo_data_in), .fifo_write_en(fifo_write_en), .fifo_full(fifo_full),
    .owner(owner),
`ifdef FIFO_WR_ARB_STALL_CNT_EN
    .stall_count(stall_count),
`endif
    .busy(busy)
  );

  fifo_write_arbiter #(.NUM_REQ(4), .DATA_WIDTH(8), .MAX_BURST(1)) dut1 (
    .clock(clock), .reset_n(reset_n), .req(req1), .req_data(req_data1), .gnt(gnt1),
    .fifo_data_in(fifo_data_in1), .fifo_write_en(fifo_write_en1), .fifo_full(fifo_full1),
    .owner(owner1),
`ifdef FIFO_WR_ARB_STALL_CNT_EN
    .stall_count(stall_count1),
`endif
    .busy(busy1)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        pre_reset;
    string       tag;
    logic [3:0]  req;
    logic [31:0] data;
    logic        full;
    logic [3:0]  e_gnt;
    logic        e_wen;
    logic [7:0]  e_data;
    logic [1:0]  e_owner;
    logic        e_busy;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void add(input logic pr, input string tag, input logic [3:0] r, input logic [31:0] d,
                              input logic f, input logic [3:0] eg, input logic ew, input logic [7:0] ed,
                              input logic [1:0] eo, input logic eb);
    vec_t v;
    v.pre_reset = pr; v.tag = tag; v.req = r; v.data = d; v.full = f;
    v.e_gnt = eg; v.e_wen = ew; v.e_data = ed; v.e_owner = eo; v.e_busy = eb;
    vecs.push_back(v);
  endfunction

  // Checked fields packed as {gnt, write_en, data, owner, busy}.
  task automatic step(input string tag, input logic [3:0] r, input logic [31:0] d, input logic f,
                      input logic [3:0] eg, input logic ew, input logic [7:0] ed,
                      input logic [1:0] eo, input logic eb);
    @(negedge clock);
    req = r; req_data = d; fifo_full = f;
    #1;
    check(tag, {48'd0, gnt, fifo_write_en, fifo_data_in, owner, busy}, {48'd0, eg, ew, ed, eo, eb});
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset_n = 1'b0; req = '0; req_data = '0; fifo_full = 1'b0;
    req1 = '0; req_data1 = '0; fifo_full1 = 1'b0;
    #1;
    check("reset_state", {56'd0, gnt, fifo_write_en, owner, busy}, {56'd0, 4'b0000, 1'b0, 2'd3, 1'b0});
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  function automatic logic [31:0] dslot0(input logic [7:0] b);
    return {8'h33, 8'h22, 8'h11, b};
  endfunction

  initial begin
    reset_n = 1'b0; req = '0; req_data = '0; fifo_full = 1'b0;
    req1 = '0; req_data1 = '0; fifo_full1 = 1'b0;

    // Single requester, six beats: burst of 4, one idle cycle, burst of 2, release.
    add(1, "s1_idle", 4'b0001, dslot0(8'hA0), 0, 4'b0000, 0, 8'h00, 2'd3, 0);
    for (int k = 0; k < 4; k++)
      add(0, "s1_beat", 4'b0001, dslot0(8'(8'hA0 + k)), 0, 4'b0001, 1, 8'(8'hA0 + k), 2'd0, 1);
    add(0, "s1_gap",  4'b0001, dslot0(8'hA4), 0, 4'b0000, 0, 8'h00, 2'd0, 0);
    add(0, "s1_beat", 4'b0001, dslot0(8'hA4), 0, 4'b0001, 1, 8'hA4, 2'd0, 1);
    add(0, "s1_beat", 4'b0001, dslot0(8'hA5), 0, 4'b0001, 1, 8'hA5, 2'd0, 1);
    add(0, "s1_rel",  4'b0000, dslot0(8'h00), 0, 4'b0000, 0, 8'h00, 2'd0, 1);
    add(0, "s1_end",  4'b0000, dslot0(8'h00), 0, 4'b0000, 0, 8'h00, 2'd0, 0);

    // All four requesting: grant order 0,1,2,3,0 with 4 beats each.
    for (int g = 0; g < 4; g++) begin
      add(g == 0, "rr_idle", 4'b1111, 32'h33221100, 0, 4'b0000, 0, 8'h00, 2'((g + 3) % 4), 0);
      for (int k = 0; k < 4; k++)
        add(0, "rr_beat", 4'b1111, 32'h33221100, 0, 4'(1 << g), 1, 8'(g * 17), 2'(g), 1);
    end
    add(0, "rr_idle", 4'b1111, 32'h33221100, 0, 4'b0000, 0, 8'h00, 2'd3, 0);
    add(0, "rr_wrap", 4'b1111, 32'h33221100, 0, 4'b0001, 1, 8'h00, 2'd0, 1);

    // Requester 1 releases after 2 beats; next search starts at 2, so 3 beats 0.
    add(1, "er_idle", 4'b0010, 32'h33221100, 0, 4'b0000, 0, 8'h00, 2'd3, 0);
    add(0, "er_beat", 4'b0010, 32'h33221100, 0, 4'b0010, 1, 8'h11, 2'd1, 1);
    add(0, "er_beat", 4'b0010, 32'h33221100, 0, 4'b0010, 1, 8'h11, 2'd1, 1);
    add(0, "er_drop", 4'b1001, 32'h33221100, 0, 4'b0000, 0, 8'h11, 2'd1, 1);
    add(0, "er_idle", 4'b1001, 32'h33221100, 0, 4'b0000, 0, 8'h00, 2'd1, 0);
    add(0, "er_next", 4'b1001, 32'h33221100, 0, 4'b1000, 1, 8'h33, 2'd3, 1);

    foreach (vecs[i]) begin
      if (vecs[i].pre_reset) do_reset();
      step($sformatf("%s[%0d]", vecs[i].tag, i), vecs[i].req, vecs[i].data, vecs[i].full,
           vecs[i].e_gnt, vecs[i].e_wen, vecs[i].e_data, vecs[i].e_owner, vecs[i].e_busy);
    end

    // Requester 2 stalled by fifo_full for 3 cycles after beat 2.
    do_reset();
    step("st_idle",  4'b0100, {8'h33, 8'hB0, 8'h11, 8'h00}, 0, 4'b0000, 0, 8'h00, 2'd3, 0);
    step("st_beat1", 4'b0100, {8'h33, 8'hB0, 8'h11, 8'h00}, 0, 4'b0100, 1, 8'hB0, 2'd2, 1);
    step("st_beat2", 4'b0100, {8'h33, 8'hB1, 8'h11, 8'h00}, 0, 4'b0100, 1, 8'hB1, 2'd2, 1);
    for (int k = 0; k < 3; k++)
      step("st_full", 4'b0100, {8'h33, 8'hB2, 8'h11, 8'h00}, 1, 4'b0000, 0, 8'hB2, 2'd2, 1);
    step("st_beat3", 4'b0100, {8'h33, 8'hB2, 8'h11, 8'h00}, 0, 4'b0100, 1, 8'hB2, 2'd2, 1);
    step("st_beat4", 4'b0100, {8'h33, 8'hB3, 8'h11, 8'h00}, 0, 4'b0100, 1, 8'hB3, 2'd2, 1);
    step("st_done",  4'b0000, 32'h0, 0, 4'b0000, 0, 8'h00, 2'd2, 0);
`ifdef FIFO_WR_ARB_STALL_CNT_EN
    check("stall_count", {48'd0, stall_count}, 64'd3);
`endif

    // Reset asserted mid-burst after the first beat.
    do_reset();
    step("rb_idle",  4'b0001, dslot0(8'hC0), 0, 4'b0000, 0, 8'h00, 2'd3, 0);
    step("rb_beat1", 4'b0001, dslot0(8'hC0), 0, 4'b0001, 1, 8'hC0, 2'd0, 1);
    @(negedge clock);
    req_data = dslot0(8'hC1);
    reset_n  = 1'b0;
    #1;
    check("rb_abort", {56'd0, gnt, fifo_write_en, owner, busy}, {56'd0, 4'b0000, 1'b0, 2'd3, 1'b0});
    @(negedge clock);
    req = '0;
    reset_n = 1'b1;
    step("rb_rearb", 4'b0011, 32'h33221100, 0, 4'b0000, 0, 8'h00, 2'd3, 0);
    step("rb_first", 4'b0011, 32'h33221100, 0, 4'b0001, 1, 8'h00, 2'd0, 1);

    // MAX_BURST=1 instance: requesters 0 and 1 alternate with an idle cycle between.
    do_reset();
    for (int k = 0; k < 8; k++) begin
      logic [1:0] eo;
      logic [3:0] eg;
      logic       eb;
      eb = k[0];
      if (k == 0)      eo = 2'd3;
      else if (eb)     eo = 2'((k / 2) % 2);
      else             eo = 2'(((k - 1) / 2) % 2);
      eg = eb ? 4'(1 << eo) : 4'b0000;
      @(negedge clock);
      req1 = 4'b0011; req_data1 = 32'h43424140;
      #1;
      check($sformatf("mb1[%0d]", k), {48'd0, gnt1, fifo_write_en1, fifo_data_in1, owner1, busy1},
            {48'd0, eg, eb, (eb ? 8'(8'h40 + eo) : 8'h00), eo, eb});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
